timer_io_capture: RTL and testbench
===================================

Name: timer_io_capture

Overview:
- Input-conditioning stage directly upstream of user_proj_timer.
- Takes the raw io_in[37:27] pad inputs (11 channels) and, per channel:
  - synchronises the input,
  - debounces it,
  - detects rising and falling edges.
- Edge events are time-stamped and queued in a small FIFO. The timer drains the FIFO through a valid/ready handshake.

Parameters:
- WIDTH, 11, number of input channels (io_in[37:27]).
- SYNC_STAGES, 2, synchroniser flops per channel (must be ≥2).
- DB_W, 16, width of the debounce limit and of each per-channel debounce counter.
- TS_W, 16, timestamp counter width.
- DEPTH, 4, event FIFO depth (power of 2).

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- io_in  in  WIDTH  raw pad inputs.
- enable_i  in  1  gates the timestamp counter and event capture.
- db_limit_i  in  DB_W  debounce length, quasi-static.
- clr_ovf_i  in  1  one-cycle pulse; clears overflow_o.
- clean_o  out  WIDTH  debounced level per channel.
- rise_o  out  WIDTH  one-cycle pulse on a debounced 0→1 transition.
- fall_o  out  WIDTH  one-cycle pulse on a debounced 1→0 transition.
- evt_valid_o  out  1  FIFO non-empty.
- evt_ready_i  in  1  consumer accepts the head entry.
- evt_data_o  out  4+1+TS_W  {chan[3:0], dir (1 = rise), ts[TS_W-1:0]}; show-ahead (head entry always visible).
- evt_count_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow_o  out  1  sticky flag: an event was dropped.

Behaviour:
- Reset:
  - One clock, wb_clk_i. Reset wb_rst_ni is asynchronous and active-low.
  - Assertion immediately clears all state: sync flops, clean_o, rise_o, fall_o, debounce counters, timestamp, FIFO pointers, evt_count_o, evt_valid_o, overflow_o. All of these are 0.
  - Release is used synchronously. FIFO contents are discarded on reset mid-operation.
- Sync: each channel passes through SYNC_STAGES flops; the output is s[i].
- Debounce, per channel, evaluated every cycle regardless of enable_i:
  - If s[i]==clean[i], then cnt[i]←0.
  - Else if cnt[i]==db_limit_i, then clean[i]←s[i] and cnt[i]←0.
  - Else cnt[i]←cnt[i]+1.
  - Net effect: a change must persist db_limit_i+1 consecutive cycles.
  - db_limit_i=0 gives a 1-cycle delay. Total latency pad→clean_o = SYNC_STAGES + db_limit_i + 1 cycles.
  - A glitch shorter than db_limit_i+1 cycles resets cnt and produces no change.
- Edges: rise_o[i]/fall_o[i] are registered and high for exactly the one cycle in which clean_o[i] first shows the new value. They are independent of enable_i.
- Timestamp:
  - TS_W-bit counter, increments every cycle while enable_i=1 and holds otherwise.
  - Wraps from all-ones to 0.
  - The event ts is the counter value in the cycle the edge pulse is high.
- Event capture, only while enable_i=1:
  - If any rise/fall pulse is high, push one event for the lowest-index channel with an edge.
  - Any other simultaneous edges are dropped and set overflow_o.
  - With enable_i=0, no pushes occur and overflow_o is not set.
- FIFO:
  - Pop when evt_valid_o & evt_ready_i.
  - Push when full:
    - Accepted if a pop occurs in the same cycle.
    - Otherwise the event is dropped and overflow_o is set.
  - Push and pop in the same cycle leave evt_count_o unchanged.
  - A pushed event is visible at evt_data_o/evt_valid_o the cycle after the edge pulse when the FIFO was empty (1-cycle latency).
  - Pointers wrap modulo DEPTH.
- overflow_o: set-dominant. If a set and clr_ovf_i occur in the same cycle, the flag stays 1.

Test Plan:
- Reset and debounce, db_limit=3:
  - Hold io_in[0]=1 from a clean reset.
  - clean_o[0] rises exactly 2+3+1=6 cycles later.
  - rise_o[0] pulses 1 cycle.
  - An event {0, 1, ts} is queued, with ts equal to the timestamp in the pulse cycle.
- Glitch rejection, db_limit=3:
  - Drive 3-cycle pulses on io_in[5].
  - clean_o, rise_o, fall_o stay 0.
  - No event is queued.
- Simultaneous edges:
  - Toggle io_in[2] and io_in[7] in the same cycle, db_limit=0.
  - Exactly one event with chan=2 is queued.
  - overflow_o=1.
  - A clr_ovf_i pulse then clears it.
- FIFO full, evt_ready_i=0:
  - Generate 5 separate edges with DEPTH=4.
  - evt_count_o=4 and overflow_o=1.
  - Drain: 4 events pop in arrival order with increasing ts.
  - evt_valid_o drops after the 4th pop.
- Full with simultaneous push and pop:
  - With 4 events queued, assert evt_ready_i in the same cycle as a new edge.
  - evt_count_o stays 4.
  - overflow_o stays 0.
- Enable gating, wrap, and reset mid-operation:
  - With enable_i=0, edges still pulse rise_o but queue nothing and the timestamp holds.
  - Preload the timestamp to 0xFFFF; it wraps to 0x0000.
  - Assert wb_rst_ni low with 2 events queued; evt_valid_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/timer_io_capture.sv
// Pad input conditioning for the timer: sync, debounce, edge detect,
// timestamped event FIFO drained over a valid/ready handshake.
//
// Ports:
//   wb_clk_i, wb_rst_ni : clock, async active-low reset
//   io_in               : raw pad inputs (WIDTH channels)
//   enable_i            : gates timestamp counting and event capture
//   db_limit_i          : debounce length (change must last limit+1 cycles)
//   clr_ovf_i           : clears overflow_o (set wins on collision)
//   clean_o             : debounced levels
//   rise_o / fall_o     : one-cycle pulses on debounced edges
//   evt_valid_o         : FIFO non-empty
//   evt_ready_i         : consumer takes the head entry
//   evt_data_o          : head entry {chan[3:0], dir, ts}
//   evt_count_o         : FIFO occupancy
//   overflow_o          : sticky, an event was dropped
module timer_io_capture #(
  parameter int WIDTH       = 11,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 16,
  parameter int TS_W        = 16,
  parameter int DEPTH       = 4
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic [WIDTH-1:0]          io_in,
  input  logic                      enable_i,
  input  logic [DB_W-1:0]           db_limit_i,
  input  logic                      clr_ovf_i,
  output logic [WIDTH-1:0]          clean_o,
  output logic [WIDTH-1:0]          rise_o,
  output logic [WIDTH-1:0]          fall_o,
  output logic                      evt_valid_o,
  input  logic                      evt_ready_i,
  output logic [4+1+TS_W-1:0]       evt_data_o,
  output logic [$clog2(DEPTH):0]    evt_count_o,
  output logic                      overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 4 + 1 + TS_W;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0][DB_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]                  clean_q, clean_d;
  logic [WIDTH-1:0]                  rise_q, fall_q;
  logic [WIDTH-1:0]                  s;
  logic [TS_W-1:0]                   ts_q;
  logic [EW-1:0]                     mem_q [DEPTH];
  logic [AW-1:0]                     wr_q, rd_q;
  logic [AW:0]                       fill_q;
  logic                              ovf_q;

  logic [WIDTH-1:0] edges;
  logic [3:0]       sel;
  logic             dir;
  logic             multi;
  logic             full;
  logic             push_req, push, pop;
  logic             drop, ovf_set;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], io_in};
    end
  end

  // Counter tracks how long s has disagreed with clean.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == db_limit_i) begin
        clean_d[i] = s[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q   <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= clean_d & ~clean_q;
      fall_q  <= ~clean_d & clean_q;
    end
  end

  // Lowest-index edge wins; descending scan leaves it last.
  always_comb begin
    edges = rise_q | fall_q;
    sel   = '0;
    dir   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (edges[i]) begin
        sel = 4'(i);
        dir = rise_q[i];
      end
    end
  end

  assign multi    = |(edges & (edges - WIDTH'(1)));
  assign full     = (fill_q == (AW+1)'(DEPTH));
  assign pop      = evt_valid_o & evt_ready_i;
  assign push_req = enable_i & (|edges);
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign ovf_set  = (enable_i & multi) | drop;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ts_q   <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (enable_i) ts_q <= ts_q + TS_W'(1);
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      unique case ({push, pop})
        2'b10:   fill_q <= fill_q + (AW+1)'(1);
        2'b01:   fill_q <= fill_q - (AW+1)'(1);
        default: fill_q <= fill_q;
      endcase
      ovf_q <= ovf_set | (ovf_q & ~clr_ovf_i);
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_q] <= {sel, dir, ts_q};
  end

  assign clean_o     = clean_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign evt_valid_o = (fill_q != '0);
  assign evt_data_o  = mem_q[rd_q];
  assign evt_count_o = fill_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_timer_io_capture.sv
// Bench for timer_io_capture: latency table, directed corner cases,
// and random traffic against a queue-based reference model.
module tb_timer_io_capture;

  localparam int W  = 11;
  localparam int NS = 2;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  io_in;
  logic          enable;
  logic [15:0]   db_limit;
  logic          clr_ovf;
  logic [W-1:0]  clean_o, rise_o, fall_o;
  logic          evt_valid_o;
  logic          ready;
  logic [20:0]   evt_data_o;
  logic [2:0]    evt_count_o;
  logic          overflow_o;

  timer_io_capture dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .io_in       (io_in),
    .enable_i    (enable),
    .db_limit_i  (db_limit),
    .clr_ovf_i   (clr_ovf),
    .clean_o     (clean_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (ready),
    .evt_data_o  (evt_data_o),
    .evt_count_o (evt_count_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b1;

  // reference model state
  logic [W-1:0]  hist [$];
  int            run [W];
  logic [W-1:0]  m_clean, m_rise, m_fall;
  logic [15:0]   m_ts;
  logic [20:0]   mq [$];
  logic          m_ovf;

  typedef struct {
    int lim;
    int ch;
    int len;
    int exp;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < NS; i++) hist.push_back('0);
    for (int i = 0; i < W; i++) run[i] = 0;
    m_clean = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_ts    = '0;
    mq.delete();
    m_ovf   = 1'b0;
  endtask

  // One clock of the model: events from pulses already showing,
  // then debounce on the value the pads had NS clocks ago.
  task automatic model_step();
    logic [W-1:0] ed, s;
    logic         set, pop;
    int           lo;
    ed  = m_rise | m_fall;
    set = 1'b0;
    pop = (mq.size() != 0) && ready;
    if (pop) void'(mq.pop_front());
    if (enable && ed != 0) begin
      lo = 0;
      for (int i = W - 1; i >= 0; i--) if (ed[i]) lo = i;
      if ($countones(ed) > 1) set = 1'b1;
      if (mq.size() < DP) mq.push_back({4'(lo), m_rise[lo], m_ts});
      else set = 1'b1;
    end
    m_ovf = set | (m_ovf & ~clr_ovf);
    if (enable) m_ts = m_ts + 16'd1;
    s = hist[0];
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < W; i++) begin
      if (s[i] != m_clean[i]) begin
        run[i]++;
        if (run[i] == int'(db_limit) + 1) begin
          m_clean[i] = s[i];
          if (s[i]) m_rise[i] = 1'b1;
          else m_fall[i] = 1'b1;
          run[i] = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
    void'(hist.pop_front());
    hist.push_back(io_in);
  endtask

  task automatic compare_all();
    logic [63:0] a, e;
    if (!cmp_on) return;
    a = {clean_o, rise_o, fall_o, evt_valid_o, evt_count_o, overflow_o};
    e = {m_clean, m_rise, m_fall, mq.size() != 0,
         3'(mq.size()), m_ovf};
    check("cycle_state", a, e);
    if (mq.size() != 0) check("cycle_head", evt_data_o, mq[0]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    io_in   = '0;
    enable  = 1'b0;
    ready   = 1'b0;
    clr_ovf = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    vecs[0] = '{3, 0, 0, 6};
    vecs[1] = '{0, 1, 0, 3};
    vecs[2] = '{3, 5, 3, 0};
    vecs[3] = '{3, 5, 4, 6};
    vecs[4] = '{1, 10, 1, 0};
    vecs[5] = '{1, 10, 2, 4};
    vecs[6] = '{7, 4, 0, 10};

    rst_n    = 1'b0;
    db_limit = 16'd3;
    @(negedge clk);
    do_reset();
    check("reset_state",
          {clean_o, rise_o, fall_o, evt_valid_o, evt_count_o, overflow_o},
          0);

    // latency / glitch table
    foreach (vecs[v]) begin
      do_reset();
      db_limit = 16'(vecs[v].lim);
      enable   = 1'b1;
      io_in[vecs[v].ch] = 1'b1;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
        tick();
        if (lat == 0 && clean_o[vecs[v].ch]) begin
          lat = k;
          check("tbl_rise", rise_o[vecs[v].ch], 1);
        end
        if (vecs[v].exp != 0 && k == vecs[v].exp + 1)
          check("tbl_evt", evt_data_o,
                {4'(vecs[v].ch), 1'b1, 16'(vecs[v].exp)});
        if (k == vecs[v].len) io_in[vecs[v].ch] = 1'b0;
      end
      check("tbl_latency", lat, vecs[v].exp);
      check("tbl_evcount", evt_count_o,
            vecs[v].exp == 0 ? 0 : (vecs[v].len == 0 ? 1 : 2));
    end

    // simultaneous edges
    do_reset();
    db_limit = 0;
    enable   = 1'b1;
    io_in[2] = 1'b1;
    io_in[7] = 1'b1;
    repeat (3) tick();
    check("sim_pulses", {rise_o[2], rise_o[7]}, 2'b11);
    tick();
    check("sim_count", evt_count_o, 1);
    check("sim_head", evt_data_o[20:16], {4'd2, 1'b1});
    check("sim_ovf", overflow_o, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("sim_ovf_clr", overflow_o, 0);

    // FIFO full then drain
    do_reset();
    db_limit = 0;
    enable   = 1'b1;
    for (int j = 0; j < 5; j++) begin
      io_in[3] = ~io_in[3];
      repeat (4) tick();
    end
    check("full_count", evt_count_o, 4);
    check("full_ovf", overflow_o, 1);
    ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("drain_head", evt_data_o,
            {4'd3, 1'(j % 2 == 0), 16'(3 + 4 * j)});
      tick();
    end
    ready = 1'b0;
    check("drain_valid", evt_valid_o, 0);

    // full with simultaneous push and pop
    do_reset();
    db_limit = 0;
    enable   = 1'b1;
    for (int j = 0; j < 4; j++) begin
      io_in[3] = ~io_in[3];
      repeat (4) tick();
    end
    check("pp_pre_count", evt_count_o, 4);
    io_in[3] = ~io_in[3];
    repeat (3) tick();
    check("pp_pulse", rise_o[3], 1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("pp_count", evt_count_o, 4);
    check("pp_ovf", overflow_o, 0);
    check("pp_head", evt_data_o, {4'd3, 1'b0, 16'd7});

    // enable gating
    do_reset();
    db_limit = 0;
    io_in[1] = 1'b1;
    repeat (3) tick();
    check("en_pulse", rise_o[1], 1);
    tick();
    check("en_noevt", evt_count_o, 0);
    io_in[1] = 1'b0;
    enable   = 1'b1;
    repeat (4) tick();
    check("en_ts_held", evt_data_o, {4'd1, 1'b0, 16'd3});

    // timestamp wrap and reset mid-operation
    do_reset();
    db_limit = 0;
    enable   = 1'b1;
    cmp_on   = 1'b0;
    repeat (65535) tick();
    cmp_on   = 1'b1;
    enable   = 1'b0;
    io_in[9] = 1'b1;
    repeat (3) tick();
    check("wrap_pulse", rise_o[9], 1);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    check("wrap_ffff", evt_data_o, {4'd9, 1'b1, 16'hFFFF});
    io_in[9] = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    check("wrap_count", evt_count_o, 2);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("wrap_0000", evt_data_o, {4'd9, 1'b0, 16'h0000});
    io_in[9] = 1'b1;
    enable   = 1'b1;
    repeat (4) tick();
    enable   = 1'b0;
    check("mid_pre_count", evt_count_o, 2);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_valid", evt_valid_o, 0);
    check("mid_rst_count", evt_count_o, 0);
    @(posedge clk);
    @(negedge clk);
    io_in = '0;
    rst_n = 1'b1;

    // random traffic against the model
    for (int b = 0; b < 4; b++) begin
      do_reset();
      db_limit = 16'($urandom_range(0, 3));
      for (int c = 0; c < 600; c++) begin
        for (int i = 0; i < W; i++)
          if ($urandom_range(0, 7) == 0) io_in[i] = ~io_in[i];
        enable  = ($urandom_range(0, 7) != 0);
        ready   = 1'($urandom_range(0, 1));
        clr_ovf = ($urandom_range(0, 15) == 0);
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
